// File: rtl/axi_write_vector_pkg.sv
// Shared types for the vector stream writer/reader pair.
package axi_write_vector_pkg;

    typedef enum logic {
        DIR__LEFT  = 1'b0,
        DIR__RIGHT = 1'b1
    } dir_t;

    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/axi_stream_if.sv
// Minimal AXI-Stream bundle: valid/ready handshake with data and last.
interface axi_stream_if #(
    parameter int unsigned W = 8
) ();
    logic         tvalid;
    logic         tready;
    logic [W-1:0] tdata;
    logic         tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/axi_write_vector.sv
// Serialises one run-time-length bit-vector onto an AXI-Stream master,
// then pulses ready for one cycle once the last beat has been accepted.
module axi_write_vector
    import axi_write_vector_pkg::*;
#(
    parameter int unsigned MAX_VEC_LENGTH   = 8,
    parameter int unsigned AXI_DATA_WIDTH   = 8,
    parameter dir_t        WRITE_DIR        = DIR__LEFT,
    parameter int unsigned MAX_VEC_LENGTH_W = (MAX_VEC_LENGTH <= 1) ? 1 : $clog2(MAX_VEC_LENGTH + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [MAX_VEC_LENGTH_W-1:0] vec_length,
    input  logic [MAX_VEC_LENGTH-1:0]   vec,
    input  logic                        last,
    output logic                        busy,
    output logic                        ready,
    axi_stream_if.master                data_out
);

    localparam int unsigned W     = AXI_DATA_WIDTH;
    localparam int unsigned NB    = (MAX_VEC_LENGTH == 0) ? 1 : ceil_div(MAX_VEC_LENGTH, W);
    localparam int unsigned SW    = NB * W;
    localparam int unsigned CNT_W = (NB <= 1) ? 1 : $clog2(NB + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                      state_q;
    logic [SW-1:0]               sr_q;
    logic [CNT_W-1:0]            beats_q;
    logic                        last_q;
    logic                        tvalid_q;
    logic                        tlast_q;
    logic                        busy_q;
    logic                        ready_q;

    logic [MAX_VEC_LENGTH_W-1:0] len_c;
    logic [MAX_VEC_LENGTH-1:0]   mask_c;
    logic [SW-1:0]               load_c;
    logic [CNT_W-1:0]            nbeats_c;

    // Clamp the length, mask off unused bits and pre-align so beat 0 sits at the output slice.
    always_comb begin
        len_c    = (vec_length > MAX_VEC_LENGTH_W'(MAX_VEC_LENGTH))
                   ? MAX_VEC_LENGTH_W'(MAX_VEC_LENGTH) : vec_length;
        mask_c   = '0;
        for (int unsigned j = 0; j < MAX_VEC_LENGTH; j++) begin
            mask_c[j] = (MAX_VEC_LENGTH_W'(j) < len_c);
        end
        if (WRITE_DIR == DIR__LEFT) begin
            load_c = SW'(vec & mask_c) << (SW - 32'(len_c));
        end else begin
            load_c = SW'(vec & mask_c);
        end
        nbeats_c = (len_c == '0) ? CNT_W'(1) : CNT_W'((32'(len_c) + W - 1) / W);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            sr_q     <= '0;
            beats_q  <= '0;
            last_q   <= 1'b0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    ready_q <= 1'b0;
                    if (start) begin
                        sr_q     <= load_c;
                        beats_q  <= nbeats_c;
                        last_q   <= last;
                        tvalid_q <= 1'b1;
                        tlast_q  <= last && (nbeats_c == CNT_W'(1));
                        busy_q   <= 1'b1;
                        state_q  <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (data_out.tready) begin
                        if (beats_q == CNT_W'(1)) begin
                            sr_q     <= '0;
                            beats_q  <= '0;
                            tvalid_q <= 1'b0;
                            tlast_q  <= 1'b0;
                            busy_q   <= 1'b0;
                            ready_q  <= 1'b1;
                            state_q  <= S_DONE;
                        end else begin
                            sr_q    <= (WRITE_DIR == DIR__LEFT) ? (sr_q << W) : (sr_q >> W);
                            beats_q <= beats_q - CNT_W'(1);
                            tlast_q <= last_q && (beats_q == CNT_W'(2));
                        end
                    end
                end
                S_DONE: begin
                    ready_q <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Current beat is the MSB slice for left packing, the LSB slice for right packing.
    generate
        if (WRITE_DIR == DIR__LEFT) begin : g_left
            assign data_out.tdata = sr_q[SW-1 -: W];
        end else begin : g_right
            assign data_out.tdata = sr_q[W-1:0];
        end
    endgenerate

    assign data_out.tvalid = tvalid_q;
    assign data_out.tlast  = tlast_q;
    assign busy            = busy_q;
    assign ready           = ready_q;

endmodule

// File: tb/tb_axi_write_vector.sv
// Scoreboard bench: two writers (left and right packing) driven in parallel,
// beats compared against a bit-level reference model of the packing rules.
module tb_axi_write_vector;
    import axi_write_vector_pkg::*;

    localparam int unsigned MAXL = 20;
    localparam int unsigned W    = 8;
    localparam int unsigned LW   = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic            last;
    logic            tready;
    logic [LW-1:0]   vec_length;
    logic [MAXL-1:0] vec;
    logic            busy_l, ready_l, busy_r, ready_r;

    always #5 clk = ~clk;

    axi_stream_if #(.W(W)) if_l ();
    axi_stream_if #(.W(W)) if_r ();
    assign if_l.tready = tready;
    assign if_r.tready = tready;

    axi_write_vector #(
        .MAX_VEC_LENGTH(MAXL), .AXI_DATA_WIDTH(W), .WRITE_DIR(DIR__LEFT), .MAX_VEC_LENGTH_W(LW)
    ) u_left (
        .clk(clk), .rst_n(rst_n), .start(start), .vec_length(vec_length), .vec(vec),
        .last(last), .busy(busy_l), .ready(ready_l), .data_out(if_l)
    );

    axi_write_vector #(
        .MAX_VEC_LENGTH(MAXL), .AXI_DATA_WIDTH(W), .WRITE_DIR(DIR__RIGHT), .MAX_VEC_LENGTH_W(LW)
    ) u_right (
        .clk(clk), .rst_n(rst_n), .start(start), .vec_length(vec_length), .vec(vec),
        .last(last), .busy(busy_r), .ready(ready_r), .data_out(if_r)
    );

    typedef struct packed {
        logic [W-1:0] data;
        logic         tlast;
        logic         fin;
    } beat_t;

    beat_t exp_l[$];
    beat_t exp_r[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: bit positions of each beat taken straight from the packing formulas.
    function automatic void push_vector(input int l_raw, input logic [MAXL-1:0] v, input logic lst);
        int              l;
        int              n;
        int              idx;
        logic [W-1:0]    bl;
        logic [W-1:0]    br;
        logic [MAXL-1:0] sh;
        beat_t           b;
        l = (l_raw > int'(MAXL)) ? int'(MAXL) : l_raw;
        n = (l == 0) ? 1 : (l + int'(W) - 1) / int'(W);
        for (int k = 0; k < n; k++) begin
            bl = '0;
            br = '0;
            for (int i = int'(W) - 1; i >= 0; i--) begin
                idx = k * int'(W) + i;
                sh  = v >> idx;
                br  = {br[W-2:0], (idx < l) ? sh[0] : 1'b0};
            end
            for (int i = 0; i < int'(W); i++) begin
                idx = l - 1 - k * int'(W) - i;
                sh  = (idx >= 0) ? (v >> idx) : '0;
                bl  = {bl[W-2:0], (idx >= 0) ? sh[0] : 1'b0};
            end
            b.tlast = lst && (k == n - 1);
            b.fin   = (k == n - 1);
            b.data  = bl;
            exp_l.push_back(b);
            b.data  = br;
            exp_r.push_back(b);
        end
    endfunction

    logic         fin_prev   [2];
    logic         stall_prev [2];
    logic [W-1:0] d_prev     [2];
    logic         l_prev     [2];

    // Monitor: samples 2 time units after the falling edge, once stimulus has settled.
    always @(negedge clk) begin
        logic         v, l, r;
        logic [W-1:0] dt;
        beat_t        e;
        string        nm;
        #2;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                fin_prev[d]   = 1'b0;
                stall_prev[d] = 1'b0;
            end else begin
                v  = (d == 0) ? if_l.tvalid : if_r.tvalid;
                dt = (d == 0) ? if_l.tdata  : if_r.tdata;
                l  = (d == 0) ? if_l.tlast  : if_r.tlast;
                r  = (d == 0) ? ready_l     : ready_r;
                nm = (d == 0) ? "L" : "R";
                chk({nm, "_ready_after_final"}, 32'(r), 32'(fin_prev[d]));
                if (r) chk({nm, "_tvalid_in_done"}, 32'(v), 32'd0);
                if (stall_prev[d]) begin
                    chk({nm, "_hold_tvalid"}, 32'(v), 32'd1);
                    chk({nm, "_hold_tdata"}, 32'(dt), 32'(d_prev[d]));
                    chk({nm, "_hold_tlast"}, 32'(l), 32'(l_prev[d]));
                end
                fin_prev[d] = 1'b0;
                if (v && tready) begin
                    if (((d == 0) ? exp_l.size() : exp_r.size()) == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL %s_extra_beat: got beat 0x%0h expected none at %0t", nm, dt, $time);
                    end else begin
                        e = (d == 0) ? exp_l.pop_front() : exp_r.pop_front();
                        chk({nm, "_tdata"}, 32'(dt), 32'(e.data));
                        chk({nm, "_tlast"}, 32'(l), 32'(e.tlast));
                        fin_prev[d] = e.fin;
                    end
                end
                stall_prev[d] = v && !tready;
                d_prev[d]     = dt;
                l_prev[d]     = l;
            end
        end
    end

    function automatic int beats_of(input int l_raw);
        int l;
        l = (l_raw > int'(MAXL)) ? int'(MAXL) : l_raw;
        return (l == 0) ? 1 : (l + int'(W) - 1) / int'(W);
    endfunction

    task automatic set_tready(input int cyc, input int stall, input bit rnd);
        if (rnd)                                         tready = ($urandom_range(0, 3) != 0);
        else if (stall != 0 && cyc >= stall && cyc < stall + 3) tready = 1'b0;
        else                                             tready = 1'b1;
    endtask

    // One start handshake; stall>0 drops tready for 3 cycles from that cycle on.
    task automatic send(input int l, input logic [MAXL-1:0] v, input logic lst, input int stall, input bit rnd);
        int cyc;
        @(negedge clk);
        vec_length = LW'(l);
        vec        = v;
        last       = lst;
        start      = 1'b1;
        push_vector(l, v, lst);
        tready     = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        vec        = MAXL'($urandom);
        vec_length = LW'($urandom);
        last       = 1'($urandom);
        cyc        = 1;
        chk("tvalid_cycle1_L", 32'(if_l.tvalid), 32'd1);
        chk("tvalid_cycle1_R", 32'(if_r.tvalid), 32'd1);
        chk("busy_cycle1", 32'({busy_l, busy_r}), 32'd3);
        set_tready(cyc, stall, rnd);
        while (!ready_r && cyc < 300) begin
            @(negedge clk);
            cyc++;
            set_tready(cyc, stall, rnd);
        end
        if (!ready_r) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: got no ready after %0d cycles expected a pulse", cyc);
        end else begin
            if (!rnd) chk("ready_latency", 32'(cyc), 32'(beats_of(l) + 1 + ((stall != 0) ? 3 : 0)));
            chk("ready_L_aligned", 32'(ready_l), 32'd1);
            chk("busy_low_in_done", 32'({busy_l, busy_r}), 32'd0);
        end
        tready = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [MAXL-1:0] rv;
        rst_n      = 1'b0;
        start      = 1'b0;
        last       = 1'b0;
        vec        = '0;
        vec_length = '0;
        tready     = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_tvalid", 32'({if_l.tvalid, if_r.tvalid}), 32'd0);
        chk("rst_tlast", 32'({if_l.tlast, if_r.tlast}), 32'd0);
        chk("rst_tdata", 32'({if_l.tdata, if_r.tdata}), 32'd0);
        chk("rst_busy", 32'({busy_l, busy_r}), 32'd0);
        chk("rst_ready", 32'({ready_l, ready_r}), 32'd0);
        rst_n = 1'b1;

        send(20, 20'hABCDE, 1'b1, 0, 1'b0);
        send(12, 20'h00ABC, 1'b0, 0, 1'b0);
        send(20, 20'hABCDE, 1'b1, 2, 1'b0);

        // Zero-length vector plus a start while busy that must be ignored.
        @(negedge clk);
        vec_length = '0;
        vec        = MAXL'($urandom);
        last       = 1'b1;
        start      = 1'b1;
        push_vector(0, vec, 1'b1);
        @(negedge clk);
        chk("l0_tdata_R", 32'(if_r.tdata), 32'd0);
        chk("l0_tlast_R", 32'(if_r.tlast), 32'd1);
        vec_length = LW'(20);
        vec        = 20'hFFFFF;
        start      = 1'b1;
        @(negedge clk);
        chk("l0_ready", 32'(ready_r), 32'd1);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("l0_no_extra_L", 32'(exp_l.size()), 32'd0);
        chk("l0_no_extra_R", 32'(exp_r.size()), 32'd0);
        chk("l0_idle_tvalid", 32'({if_l.tvalid, if_r.tvalid}), 32'd0);

        // Reset while beat 2 is on the bus.
        @(negedge clk);
        vec_length = LW'(20);
        vec        = 20'h5A3C1;
        last       = 1'b1;
        start      = 1'b1;
        push_vector(20, vec, 1'b1);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_tvalid", 32'({if_l.tvalid, if_r.tvalid}), 32'd0);
        chk("midrst_tlast", 32'({if_l.tlast, if_r.tlast}), 32'd0);
        chk("midrst_busy", 32'({busy_l, busy_r}), 32'd0);
        chk("midrst_ready", 32'({ready_l, ready_r}), 32'd0);
        exp_l.delete();
        exp_r.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send(20, 20'h13579, 1'b1, 0, 1'b0);

        for (int i = 0; i < 200; i++) begin
            rv = MAXL'($urandom);
            send(int'($urandom_range(0, 31)), rv, 1'($urandom_range(0, 1)), 0, 1'(i % 2));
        end

        repeat (4) @(negedge clk);
        chk("final_drain_L", 32'(exp_l.size()), 32'd0);
        chk("final_drain_R", 32'(exp_r.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
